demux_4_to_16: RTL and testbench

//   Registered 1-to-16 demultiplexer. Routes the 1-bit input 'in' to the one

---
 rtl/demux_4_to_16_pkg.sv | 14 +
 rtl/demux_4_to_16_if.sv | 17 +
 rtl/demux_4_to_16_decoder.sv | 24 ++
 rtl/demux_4_to_16.sv | 35 +++
 tb/tb_demux_4_to_16.sv | 122 ++++++++++++
 5 files changed

// File: rtl/demux_4_to_16_pkg.sv
// Shared constants and types for the registered 1-to-16 demultiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux_4_to_16_pkg;

   localparam int SEL_W = 4;
   localparam int OUT_N = 1 << SEL_W;

   typedef logic [SEL_W-1:0] sel_t;
   typedef logic [OUT_N-1:0] y_t;

   localparam y_t Y_RST = 16'h0000;

endpackage : demux_4_to_16_pkg

// File: rtl/demux_4_to_16_if.sv
// Steering bus for the demultiplexer: select, data bit and the 16-bit result.
// Latency: n/a (wires only).
// Backpressure: none; master drives sel/in, slave returns y.
//   sel : select, sel = k steers in to y[k]
//   in  : data bit to steer
//   y   : registered one-hot-or-zero output
interface demux_4_to_16_if;
   import demux_4_to_16_pkg::*;

   sel_t sel;
   logic in;
   y_t   y;

   modport master (output sel, output in, input y);
   modport slave  (input sel, input in, output y);

endinterface : demux_4_to_16_if

// File: rtl/demux_4_to_16_decoder.sv
// Combinational 4-to-16 one-hot decoder with enable; all zero when en = 0.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
//   en  : enable, gates the single active output bit
//   sel : index of the bit to raise
//   dec : one-hot-or-zero decode
module decoder_4_to_16
   import demux_4_to_16_pkg::*;
(
   input  logic en,
   input  sel_t sel,
   output y_t   dec
);

   always_comb begin
      dec = '0;
      for (int k = 0; k < OUT_N; k++) begin
         if (sel == SEL_W'(k)) begin
            dec[k] = en;
         end
      end
   end

endmodule : decoder_4_to_16

// File: rtl/demux_4_to_16.sv
// Registered 1-to-16 demux: steers bus.in onto bus.y[bus.sel], other bits 0.
// Latency: 1 clock from sel/in to y.
// Backpressure: none; a new sel/in pair is accepted every clock.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears y
//   bus   : slave side of the steering bus (sel, in in; y out)
module demux_4_to_16
   import demux_4_to_16_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   demux_4_to_16_if.slave    bus
);

   y_t dec;
   y_t y_q;

   // The data bit doubles as the decoder enable, so in = 0 yields all zeros.
   decoder_4_to_16 u_dec (
      .en  (bus.in),
      .sel (bus.sel),
      .dec (dec)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         y_q <= Y_RST;
      end else begin
         y_q <= dec;
      end
   end

   assign bus.y = y_q;

endmodule : demux_4_to_16

// File: tb/tb_demux_4_to_16.sv
module tb_demux_4_to_16;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   logic [15:0] exp_q[$];
   bit   stim_done;

   demux_4_to_16_if dif ();

   demux_4_to_16 dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (dif)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Drive a vector between edges and queue the response the next edge must produce.
   task automatic apply(input logic [3:0] s, input logic i, input logic [15:0] e);
      @(negedge clk);
      dif.sel = s;
      dif.in  = i;
      exp_q.push_back(e);
   endtask

   // Scoreboard monitor: y is presented once per edge; pop and compare.
   initial begin
      logic [15:0] e;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("scoreboard", dif.y, e);
         end
      end
   end

   // Invariant monitor: at most one bit set, and y equals the model of the inputs seen at the edge.
   initial begin
      logic [15:0] g;
      forever begin
         @(posedge clk);
         g = (rst_n && dif.in) ? (16'h0001 << dif.sel) : 16'h0000;
         #1;
         check("onehot", 16'($countones(dif.y) <= 1), 16'h0001);
         check("golden", dif.y, g);
      end
   end

   logic [15:0] sweep_exp [16] = '{
      16'h0001, 16'h0002, 16'h0004, 16'h0008,
      16'h0010, 16'h0020, 16'h0040, 16'h0080,
      16'h0100, 16'h0200, 16'h0400, 16'h0800,
      16'h1000, 16'h2000, 16'h4000, 16'h8000
   };

   initial begin
      checks    = 0;
      errors    = 0;
      stim_done = 1'b0;
      rst_n     = 1'b0;
      dif.in    = 1'b1;
      dif.sel   = 4'd5;
      #2;
      check("reset_before_clk", dif.y, 16'h0000);

      // Release reset between edges.
      @(negedge clk);
      #1 rst_n = 1'b1;

      // Sweep with in = 1.
      for (int k = 0; k < 16; k++) begin
         apply(4'(k), 1'b1, sweep_exp[k]);
      end

      // in = 0 gives all zeros regardless of select.
      apply(4'd0,  1'b0, 16'h0000);
      apply(4'd7,  1'b0, 16'h0000);
      apply(4'd15, 1'b0, 16'h0000);

      // Simultaneous change of sel and in.
      apply(4'd3,  1'b0, 16'h0000);
      apply(4'd12, 1'b1, 16'h1000);

      // Mid-operation asynchronous reset.
      apply(4'd10, 1'b1, 16'h0400);
      @(negedge clk);
      #1 rst_n = 1'b0;
      #1 check("async_reset_mid", dif.y, 16'h0000);
      #1 rst_n = 1'b1;
      #1 check("reset_holds_until_edge", dif.y, 16'h0000);
      exp_q.push_back(16'h0400);
      @(posedge clk);

      apply(4'd1, 1'b1, 16'h0002);
      apply(4'd1, 1'b0, 16'h0000);

      // Bounded drain of the scoreboard.
      for (int n = 0; n < 20 && exp_q.size() > 0; n++) begin
         @(posedge clk);
      end
      #2;
      check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
      stim_done = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_demux_4_to_16
